// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into 32-bit words for the debug/boot
// injection path, expanding LI into LUI+ADDI and flagging unencodable requests on err_o.
module instr_encoder #(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [3:0]             req_op_i,
    input  logic                   req_imm_v_i,
    input  logic [4:0]             req_rd_i,
    input  logic [4:0]             req_rs1_i,
    input  logic [4:0]             req_rs2_i,
    input  logic signed [XLEN-1:0] req_imm_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [2:0]             req_cond_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [XLEN-1:0]        instr_o,
    output logic                   err_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic {S_IDLE, S_LI2} state_t;

    state_t          state;
    logic [XLEN-1:0] pend_p1;

    logic [XLEN-1:0] word0_p0;
    logic [XLEN-1:0] word1_p0;
    logic            need2_p0;
    logic            bad_p0;
    logic [2:0]      alu_f3;
    logic            alu_alt;
    logic            alu_shift;
    logic [19:0]     li_hi;
    logic [11:0]     li_lo;
    logic            accept;

    function automatic logic fits_signed(input logic signed [XLEN-1:0] v, input int bits);
        logic signed [XLEN-1:0] sh;
        sh = v >>> (bits - 1);
        return (sh == '0) || (sh == '1);
    endfunction

    function automatic logic [XLEN-1:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                               input logic [4:0] rs1, input logic [2:0] f3,
                                               input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [XLEN-1:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                               input logic [2:0] f3, input logic [4:0] rd,
                                               input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [XLEN-1:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                               input logic [4:0] rs1, input logic [2:0] f3,
                                               input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // imm12_1 holds offset bits [12:1]; bit 0 is implicitly zero
    function automatic logic [XLEN-1:0] b_type(input logic [11:0] imm12_1, input logic [4:0] rs2,
                                               input logic [4:0] rs1, input logic [2:0] f3,
                                               input logic [6:0] opc);
        return {imm12_1[11], imm12_1[9:4], rs2, rs1, f3, imm12_1[3:0], imm12_1[10], opc};
    endfunction

    // imm20_1 holds offset bits [20:1]
    function automatic logic [XLEN-1:0] j_type(input logic [19:0] imm20_1, input logic [4:0] rd,
                                               input logic [6:0] opc);
        return {imm20_1[19], imm20_1[9:0], imm20_1[10], imm20_1[18:11], rd, opc};
    endfunction

    function automatic logic [XLEN-1:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                               input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    assign li_hi = req_imm_i[XLEN-1:12] + {19'b0, req_imm_i[11]};
    assign li_lo = req_imm_i[11:0];

    always_comb begin
        alu_f3    = 3'b000;
        alu_alt   = 1'b0;
        alu_shift = 1'b0;
        case (req_op_i)
            4'h1:    alu_alt = 1'b1;
            4'h2:    begin alu_f3 = 3'b001; alu_shift = 1'b1; end
            4'h3:    alu_f3 = 3'b010;
            4'h4:    alu_f3 = 3'b011;
            4'h5:    alu_f3 = 3'b100;
            4'h6:    begin alu_f3 = 3'b101; alu_shift = 1'b1; end
            4'h7:    begin alu_f3 = 3'b101; alu_shift = 1'b1; alu_alt = 1'b1; end
            4'h8:    alu_f3 = 3'b110;
            4'h9:    alu_f3 = 3'b111;
            default: alu_f3 = 3'b000;
        endcase
    end

    // Stage p0: combinational encode of the presented request
    always_comb begin
        word0_p0 = '0;
        word1_p0 = '0;
        need2_p0 = 1'b0;
        bad_p0   = 1'b0;
        case (req_op_i)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                if (!req_imm_v_i) begin
                    word0_p0 = r_type(alu_alt ? F7_ALT : 7'b0, req_rs2_i, req_rs1_i, alu_f3,
                                      req_rd_i, OPC_OP);
                end else if (req_op_i == 4'h1) begin
                    bad_p0 = 1'b1;
                end else if (alu_shift) begin
                    bad_p0   = (req_imm_i[XLEN-1:5] != '0);
                    word0_p0 = i_type({alu_alt ? F7_ALT : 7'b0, req_imm_i[4:0]}, req_rs1_i,
                                      alu_f3, req_rd_i, OPC_OP_IMM);
                end else begin
                    bad_p0   = !fits_signed(req_imm_i, 12);
                    word0_p0 = i_type(req_imm_i[11:0], req_rs1_i, alu_f3, req_rd_i, OPC_OP_IMM);
                end
            end
            4'hA: begin
                bad_p0   = (req_size_i == 2'b11) || (req_unsigned_i && req_size_i == 2'b10) ||
                           !fits_signed(req_imm_i, 12);
                word0_p0 = i_type(req_imm_i[11:0], req_rs1_i, {req_unsigned_i, req_size_i},
                                  req_rd_i, OPC_LOAD);
            end
            4'hB: begin
                bad_p0   = (req_size_i == 2'b11) || !fits_signed(req_imm_i, 12);
                word0_p0 = s_type(req_imm_i[11:0], req_rs2_i, req_rs1_i, {1'b0, req_size_i},
                                  OPC_STORE);
            end
            4'hC: begin
                bad_p0   = (req_cond_i == 3'b010) || (req_cond_i == 3'b011) ||
                           req_imm_i[0] || !fits_signed(req_imm_i, 13);
                word0_p0 = b_type(req_imm_i[12:1], req_rs2_i, req_rs1_i, req_cond_i, OPC_BRANCH);
            end
            4'hD: begin
                bad_p0   = req_imm_i[0] || !fits_signed(req_imm_i, 21);
                word0_p0 = j_type(req_imm_i[20:1], req_rd_i, OPC_JAL);
            end
            4'hE: begin
                bad_p0   = !fits_signed(req_imm_i, 12);
                word0_p0 = i_type(req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, OPC_JALR);
            end
            4'hF: begin
                // Writes to x0 are discarded, so any LI x0 collapses to a canonical NOP
                if (req_rd_i == 5'd0) begin
                    word0_p0 = i_type(12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM);
                end else if (fits_signed(req_imm_i, 12)) begin
                    word0_p0 = i_type(li_lo, 5'd0, 3'b000, req_rd_i, OPC_OP_IMM);
                end else begin
                    word0_p0 = u_type(li_hi, req_rd_i, OPC_LUI);
                    need2_p0 = (li_lo != 12'h000);
                    word1_p0 = i_type(li_lo, req_rd_i, 3'b000, req_rd_i, OPC_OP_IMM);
                end
            end
        endcase
        if (bad_p0) begin
            word0_p0 = '0;
            need2_p0 = 1'b0;
        end
    end

    assign req_ready_o = !rst && (state == S_IDLE) && (!instr_valid_o || instr_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    // Stage p1: registered output word plus pending second LI beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            err_o         <= 1'b0;
            pend_p1       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        instr_valid_o <= 1'b1;
                        instr_o       <= word0_p0;
                        err_o         <= bad_p0;
                        if (need2_p0) begin
                            pend_p1 <= word1_p0;
                            state   <= S_LI2;
                        end
                    end else if (instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                    end
                end
                S_LI2: begin
                    if (instr_ready_i) begin
                        instr_valid_o <= 1'b1;
                        instr_o       <= pend_p1;
                        err_o         <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, LI expansion,
// illegal requests, output backpressure and reset in the middle of an LI pair.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic        req_imm_v_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic signed [31:0] req_imm_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [2:0]  req_cond_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_imm_v_i(req_imm_v_i),
        .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_imm_i(req_imm_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_cond_i(req_cond_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] op, input logic immv, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [1:0] size, input logic uns, input logic [2:0] cond);
        req_valid_i    = 1'b1;
        req_op_i       = op;
        req_imm_v_i    = immv;
        req_rd_i       = rd;
        req_rs1_i      = rs1;
        req_rs2_i      = rs2;
        req_imm_i      = imm;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_cond_i     = cond;
    endtask

    // One-beat accept: present request, clock it in, drop valid, check the output word
    task automatic one(input string tag, input logic [3:0] op, input logic immv,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [1:0] size, input logic uns,
                       input logic [2:0] cond, input logic [31:0] exp_word, input logic exp_err);
        req(op, immv, rd, rs1, rs2, imm, size, uns, cond);
        #1;
        check({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
        check({tag, "_word"}, instr_o, exp_word);
        check({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        req(4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 2'b00, 1'b0, 3'b000);
        req_valid_i = 1'b0;
        step();
        step();
        check("rst_ready", {31'b0, req_ready_o}, 32'd0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", {31'b0, req_ready_o}, 32'd1);

        one("add", 4'h0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 1'b0, 3'b000, 32'h002081B3, 1'b0);
        step();
        check("add_drained", {31'b0, instr_valid_o}, 32'd0);

        // LI needing LUI+ADDI
        one("li1_lui", 4'hF, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 2'b00, 1'b0, 3'b000,
            32'h123452B7, 1'b0);
        check("li1_busy", {31'b0, req_ready_o}, 32'd0);
        step();
        check("li1_addi", instr_o, 32'h67828293);
        check("li1_addi_valid", {31'b0, instr_valid_o}, 32'd1);

        // LI with upper rounding from imm[11]
        one("li2_lui", 4'hF, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00000800, 2'b00, 1'b0, 3'b000,
            32'h000010B7, 1'b0);
        check("li2_busy", {31'b0, req_ready_o}, 32'd0);
        step();
        check("li2_addi", instr_o, 32'h80008093);

        one("li_m1", 4'hF, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 2'b00, 1'b0, 3'b000,
            32'hFFF00113, 1'b0);
        check("li_m1_single", {31'b0, req_ready_o}, 32'd1);
        one("li_x0", 4'hF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h12345678, 2'b00, 1'b0, 3'b000,
            32'h00000013, 1'b0);
        check("li_x0_single", {31'b0, req_ready_o}, 32'd1);
        one("li_lui_only", 4'hF, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 2'b00, 1'b0, 3'b000,
            32'hABCDE3B7, 1'b0);
        check("li_lui_only_single", {31'b0, req_ready_o}, 32'd1);

        one("sub", 4'h1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 2'b00, 1'b0, 3'b000, 32'h403100B3, 1'b0);
        one("srai", 4'h7, 1'b1, 5'd4, 5'd6, 5'd0, 32'd3, 2'b00, 1'b0, 3'b000, 32'h40335213, 1'b0);
        one("lbu", 4'hA, 1'b0, 5'd5, 5'd10, 5'd0, 32'hFFFFFFFC, 2'b00, 1'b1, 3'b000,
            32'hFFC54283, 1'b0);
        one("sw", 4'hB, 1'b0, 5'd0, 5'd2, 5'd8, 32'd12, 2'b10, 1'b0, 3'b000, 32'h00812623, 1'b0);
        one("jal", 4'hD, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 2'b00, 1'b0, 3'b000, 32'h008000EF, 1'b0);
        one("beq", 4'hC, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 2'b00, 1'b0, 3'b000, 32'h00208463, 1'b0);

        // Illegal requests: zero word with err, single beat
        one("br_odd", 4'hC, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 2'b00, 1'b0, 3'b000, 32'h0, 1'b1);
        check("br_odd_single", {31'b0, req_ready_o}, 32'd1);
        one("slli32", 4'h2, 1'b1, 5'd1, 5'd1, 5'd0, 32'd32, 2'b00, 1'b0, 3'b000, 32'h0, 1'b1);
        one("subi", 4'h1, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1, 2'b00, 1'b0, 3'b000, 32'h0, 1'b1);
        one("lwu", 4'hA, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 2'b10, 1'b1, 3'b000, 32'h0, 1'b1);
        one("big_li_err_clear", 4'h0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 1'b0, 3'b000,
            32'h002081B3, 1'b0);
        step();

        // Backpressure: output held while consumer stalls, queued request waits
        instr_ready_i = 1'b0;
        one("bp_add", 4'h0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 1'b0, 3'b000, 32'h002081B3, 1'b0);
        req(4'h5, 1'b0, 5'd7, 5'd8, 5'd9, 32'd0, 2'b00, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {31'b0, req_ready_o}, 32'd0);
            check("bp_hold", instr_o, 32'h002081B3);
            check("bp_valid", {31'b0, instr_valid_o}, 32'd1);
            step();
        end
        instr_ready_i = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        check("bp_xor", instr_o, 32'h009443B3);
        check("bp_xor_valid", {31'b0, instr_valid_o}, 32'd1);
        step();

        // Reset while the ADDI beat is pending
        one("rli_lui", 4'hF, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678, 2'b00, 1'b0, 3'b000,
            32'h123452B7, 1'b0);
        rst = 1'b1;
        step();
        check("rli_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rli_instr", instr_o, 32'h0);
        check("rli_ready_in_rst", {31'b0, req_ready_o}, 32'd0);
        rst = 1'b0;
        step();
        check("rli_no_addi", {31'b0, instr_valid_o}, 32'd0);
        check("rli_ready", {31'b0, req_ready_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
